// File: rtl/uart_pkg.sv
// Shared UART definitions: parity/stop mode codes, FSM encodings
// and sizing helpers used by the receive and transmit paths.
package uart_pkg;

    localparam int CHECK_NONE = 0;
    localparam int CHECK_EVEN = 1;
    localparam int CHECK_ODD  = 2;
    localparam int CHECK_ZERO = 3;
    localparam int CHECK_ONE  = 4;

    localparam int STOP_ONE      = 0;
    localparam int STOP_ONE_HALF = 1;
    localparam int STOP_TWO      = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Rounded clocks per oversample tick, never below 1.
    function automatic int calc_div(int clk_hz, int baud, int os);
        int den;
        int q;
        den = baud * os;
        q = (clk_hz + den / 2) / den;
        return (q < 1) ? 1 : q;
    endfunction

    function automatic int cnt_width(int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic parity_exp(logic [8:0] d, int mode);
        logic p;
        case (mode)
            CHECK_ODD:  p = ~^d;
            CHECK_ZERO: p = 1'b0;
            CHECK_ONE:  p = 1'b1;
            default:    p = ^d;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count.
// Head data reads as zero while the FIFO is empty.
module uart_sync_fifo
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full_o   = (count_q == FULL_CNT);
        empty_o  = (count_q == '0);
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW + 1)'(do_push)
                           - (AW + 1)'(do_pop);
        rdata_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    end

    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-vote sampling, parity and
// framing tags, break detection and a back-pressured receive FIFO.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int system_clk = 50_000_000,
    parameter int band_rate  = 9600,
    parameter int data_bits  = 8,
    parameter int check_mode = 1,
    parameter int stop_mode  = 0,
    parameter int oversample = 16,
    parameter int fifo_depth = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_en,
    input  logic                          rx,
    output logic [data_bits-1:0]          data_out,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          data_out_valid,
    input  logic                          data_out_ready,
    output logic [$clog2(fifo_depth):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic                          break_det
);

    localparam int DIV = calc_div(system_clk, band_rate, oversample);
    localparam int TCW = cnt_width(DIV);
    localparam int OSW = $clog2(oversample);
    localparam int BCW = 4;
    localparam int WW  = data_bits + 2;

    localparam logic [TCW-1:0] T_LAST = TCW'(DIV - 1);
    localparam logic [OSW-1:0] S_LO   = OSW'(oversample / 2 - 1);
    localparam logic [OSW-1:0] S_MID  = OSW'(oversample / 2);
    localparam logic [OSW-1:0] S_HI   = OSW'(oversample / 2 + 1);
    localparam logic [OSW-1:0] S_END  = OSW'(oversample - 1);
    localparam logic [BCW-1:0] B_LAST = BCW'(data_bits - 1);

    rx_state_e state_q, state_d;

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [TCW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [OSW-1:0]       os_cnt_q, os_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [data_bits-1:0] data_q, data_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 brk_q, brk_d;
    logic                 ovf_q, ovf_d;

    logic                 tick, fall, vote;
    logic                 bit_done, bit_end;
    logic                 push, pop;
    logic                 fifo_full, fifo_empty;
    logic [WW-1:0]        push_word, head_word;

    assign tick     = (tick_cnt_q == T_LAST);
    assign fall     = rx_prev_q & ~rx_sync_q;
    assign vote     = (samp_q[0] & samp_q[1])
                    | (samp_q[0] & rx_sync_q)
                    | (samp_q[1] & rx_sync_q);
    assign bit_done = tick & (os_cnt_q == S_HI);
    assign bit_end  = tick & (os_cnt_q == S_END);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);
        os_cnt_d   = os_cnt_q;
        samp_d     = samp_q;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        brk_d      = 1'b0;
        push       = 1'b0;

        if (tick) begin
            os_cnt_d = os_cnt_q + OSW'(1);
            if (os_cnt_q == S_LO)  samp_d[0] = rx_sync_q;
            if (os_cnt_q == S_MID) samp_d[1] = rx_sync_q;
        end

        unique case (state_q)
            RX_IDLE: begin
                if (rx_en && fall) begin
                    state_d    = RX_START;
                    tick_cnt_d = '0;
                    os_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                    par_bit_d  = 1'b0;
                    stop2_d    = 1'b0;
                end
            end
            RX_START: begin
                if (bit_done && vote) begin
                    state_d = RX_IDLE;
                end else if (bit_end) begin
                    state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_done) begin
                    data_d = {vote, data_q[data_bits-1:1]};
                end
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + BCW'(1);
                    if (bit_cnt_q == B_LAST) begin
                        state_d = (check_mode != CHECK_NONE)
                                ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (bit_done) begin
                    par_bit_d = vote;
                    par_err_d = vote
                        != parity_exp(9'(data_q), check_mode);
                end
                if (bit_end) begin
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_done) begin
                    if (!vote) frm_err_d = 1'b1;
                    // A zero first stop after an all-zero frame is a break.
                    if (!stop2_q && !vote && !par_bit_q
                        && data_q == '0) begin
                        brk_d   = 1'b1;
                        state_d = RX_WAIT_IDLE;
                    end else if (stop_mode == STOP_TWO && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        push    = 1'b1;
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_sync_q) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase

        if (!rx_en) begin
            state_d = RX_IDLE;
            push    = 1'b0;
            brk_d   = 1'b0;
        end
    end

    assign push_word = {frm_err_d, par_err_q, data_q};
    assign pop       = data_out_ready & ~fifo_empty;
    assign ovf_d     = (push & fifo_full & ~pop)
                     | (ovf_q & ~clear_overflow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RX_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
            samp_q     <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            brk_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            tick_cnt_q <= tick_cnt_d;
            os_cnt_q   <= os_cnt_d;
            samp_q     <= samp_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            brk_q      <= brk_d;
            ovf_q      <= ovf_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_word),
        .pop_i   (pop),
        .rdata_o (head_word),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign data_out       = head_word[data_bits-1:0];
    assign parity_err     = head_word[data_bits];
    assign frame_err      = head_word[data_bits+1];
    assign data_out_valid = ~fifo_empty;
    assign overflow       = ovf_q;
    assign break_det      = brk_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench: even-parity/8x and odd-parity/16x receivers on one line,
// both checked against a scoreboard of expected FIFO words.
module tb_uart_rx_os;

    localparam int BIT = 80;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_en = 1'b0;
    logic rx = 1'b1;
    logic rdy1 = 1'b0;
    logic rdy2 = 1'b0;
    logic clr = 1'b0;

    logic [7:0] d1, d2;
    logic       pe1, fe1, v1, ov1, bk1;
    logic       pe2, fe2, v2, ov2, bk2;
    logic [4:0] cnt1, cnt2;

    int checks = 0;
    int errors = 0;
    int brk1 = 0;
    int brk2 = 0;
    int b1, b2;

    logic [9:0] q1[$];
    logic [9:0] q2[$];
    logic       ovx1 = 1'b0;
    logic       ovx2 = 1'b0;
    logic [7:0] dd;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bk1) brk1 <= brk1 + 1;
        if (bk2) brk2 <= brk2 + 1;
    end

    uart_rx_os #(
        .system_clk (800_000), .band_rate (10_000),
        .data_bits (8), .check_mode (1), .stop_mode (0),
        .oversample (8), .fifo_depth (16)
    ) u1 (
        .clk (clk), .rst_n (rst_n), .rx_en (rx_en), .rx (rx),
        .data_out (d1), .parity_err (pe1), .frame_err (fe1),
        .data_out_valid (v1), .data_out_ready (rdy1),
        .fifo_count (cnt1), .overflow (ov1),
        .clear_overflow (clr), .break_det (bk1)
    );

    uart_rx_os #(
        .system_clk (800_000), .band_rate (10_000),
        .data_bits (8), .check_mode (2), .stop_mode (0),
        .oversample (16), .fifo_depth (16)
    ) u2 (
        .clk (clk), .rst_n (rst_n), .rx_en (rx_en), .rx (rx),
        .data_out (d2), .parity_err (pe2), .frame_err (fe2),
        .data_out_valid (v2), .data_out_ready (rdy2),
        .fifo_count (cnt2), .overflow (ov2),
        .clear_overflow (clr), .break_det (bk2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [9:0] w1, input logic [9:0] w2);
        if (q1.size() < 16) q1.push_back(w1);
        else ovx1 = 1'b1;
        if (q2.size() < 16) q2.push_back(w2);
        else ovx2 = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb,
                              input logic sb, input logic exp);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (BIT) @(negedge clk);
        end
        rx = pb;
        repeat (BIT) @(negedge clk);
        rx = sb;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (BIT) @(negedge clk);
        if (exp) sb_push({~sb, pb ^ (^d), d}, {~sb, pb ^ ~(^d), d});
    endtask

    task automatic drain1();
        int n = 0;
        while (v1 && n < 20) begin
            chk("u1.pending", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0)
                chk("u1.word", 32'({fe1, pe1, d1}), 32'(q1.pop_front()));
            rdy1 = 1'b1;
            @(negedge clk);
            rdy1 = 1'b0;
            n++;
        end
        chk("u1.left", 32'(q1.size()), 32'd0);
        chk("u1.cnt0", 32'(cnt1), 32'd0);
    endtask

    task automatic drain2();
        int n = 0;
        while (v2 && n < 20) begin
            chk("u2.pending", 32'(q2.size() > 0), 32'd1);
            if (q2.size() > 0)
                chk("u2.word", 32'({fe2, pe2, d2}), 32'(q2.pop_front()));
            rdy2 = 1'b1;
            @(negedge clk);
            rdy2 = 1'b0;
            n++;
        end
        chk("u2.left", 32'(q2.size()), 32'd0);
        chk("u2.cnt0", 32'(cnt2), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.data", 32'(d1), 32'd0);
        chk("rst.tags", 32'({fe1, pe1}), 32'd0);
        chk("rst.valid", 32'(v1), 32'd0);
        chk("rst.cnt", 32'(cnt1), 32'd0);
        chk("rst.ovf", 32'(ov1), 32'd0);
        chk("rst.brk", 32'(bk1), 32'd0);
        chk("rst.u2", 32'({v2, cnt2, ov2, bk2}), 32'd0);
        rst_n = 1'b1;
        rx_en = 1'b1;
        repeat (5) @(negedge clk);

        send_frame(8'h3B, 1'b1, 1'b1, 1'b1);
        chk("t1.cnt", 32'(cnt1), 32'd1);
        chk("t1.valid", 32'(v1), 32'd1);
        drain1();
        drain2();

        send_frame(8'h3B, 1'b0, 1'b1, 1'b1);
        send_frame(8'h3B, 1'b1, 1'b0, 1'b1);
        chk("t2.cnt", 32'(cnt1), 32'd2);
        drain1();
        drain2();

        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("t4.cnt1", 32'(cnt1), 32'd0);
        chk("t4.cnt2", 32'(cnt2), 32'd0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        chk("t4.after", 32'(cnt1), 32'd1);
        drain1();
        drain2();

        for (int i = 0; i < 17; i++) begin
            dd = 8'(i * 37 + 5);
            send_frame(dd, ^dd, 1'b1, 1'b1);
        end
        chk("t5.cnt1", 32'(cnt1), 32'd16);
        chk("t5.ovf1", 32'(ov1), 32'(ovx1));
        chk("t5.ovf1set", 32'(ov1), 32'd1);
        chk("t5.cnt2", 32'(cnt2), 32'd16);
        chk("t5.ovf2", 32'(ov2), 32'(ovx2));

        dd = 8'h77;
        fork
            send_frame(dd, ^dd, 1'b1, 1'b1);
            begin
                repeat (862) @(negedge clk);
                chk("t5.full", 32'(cnt1), 32'd16);
                chk("t5.head", 32'({fe1, pe1, d1}), 32'(q1[0]));
                void'(q1.pop_front());
                rdy1 = 1'b1;
                @(negedge clk);
                rdy1 = 1'b0;
                chk("t5.pushpop", 32'(cnt1), 32'd16);
            end
        join
        chk("t5.cnt1b", 32'(cnt1), 32'd16);
        chk("t5.sticky", 32'(ov1), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        ovx1 = 1'b0;
        ovx2 = 1'b0;
        chk("t5.clr1", 32'(ov1), 32'(ovx1));
        chk("t5.clr2", 32'(ov2), 32'(ovx2));
        drain1();
        drain2();
        rdy1 = 1'b1;
        @(negedge clk);
        rdy1 = 1'b0;
        chk("t5.emptypop", 32'({v1, cnt1}), 32'd0);

        b1 = brk1;
        b2 = brk2;
        rx = 1'b0;
        repeat (12 * BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("t6.brk1", 32'(brk1 - b1), 32'd1);
        chk("t6.brk2", 32'(brk2 - b2), 32'd1);
        chk("t6.nopush", 32'({cnt1, cnt2}), 32'd0);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1);
        chk("t6.after", 32'(cnt1), 32'd1);
        drain1();
        drain2();

        b1 = brk1;
        fork
            send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
            begin
                repeat (4 * BIT) @(negedge clk);
                rx_en = 1'b0;
            end
        join
        rx_en = 1'b1;
        repeat (BIT) @(negedge clk);
        chk("t6.abort1", 32'(cnt1), 32'd0);
        chk("t6.abort2", 32'(cnt2), 32'd0);
        chk("t6.abortbrk", 32'(brk1 - b1), 32'd0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
        chk("t6.recover", 32'(cnt1), 32'd1);
        drain1();
        drain2();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
